// File: rtl/rr_decode_arbiter.sv
// 16-requester round-robin arbiter with registered index/one-hot grant and a
// hold-time limit that forces rotation when other requesters are waiting.
module rr_decode_arbiter #(
    parameter int unsigned N_REQ    = 16,
    parameter int unsigned IDX_W    = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             En,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             preempt
);

    localparam int unsigned HoldW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HoldW-1:0] HoldLast = HoldW'(MAX_HOLD - 1);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [HoldW-1:0]   hold_q, hold_d;
    logic               valid_q, valid_d;
    logic               pre_q, pre_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W:0]     win, win_x;
    logic [N_REQ-1:0]   own;

    // Returns {found, index}; descending overwrite leaves the first hit from start.
    function automatic logic [IDX_W:0] search(input logic [N_REQ-1:0] r,
                                              input logic [IDX_W-1:0] start);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] idx;
        res = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = start + IDX_W'(i);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        own   = '0;
        own[idx_q] = 1'b1;
        win   = search(req, ptr_q);
        win_x = search(req & ~own, ptr_q);

        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        pre_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                valid_d = 1'b0;
                if (En && win[IDX_W]) begin
                    idx_d   = win[IDX_W-1:0];
                    valid_d = 1'b1;
                    ptr_d   = win[IDX_W-1:0] + IDX_W'(1);
                    hold_d  = '0;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (!req[idx_q]) begin
                    // Release takes priority over a coincident timeout.
                    if (En && win[IDX_W]) begin
                        idx_d  = win[IDX_W-1:0];
                        ptr_d  = win[IDX_W-1:0] + IDX_W'(1);
                        hold_d = '0;
                    end else begin
                        valid_d = 1'b0;
                        hold_d  = '0;
                        state_d = StIdle;
                    end
                end else if (MAX_HOLD != 0 && hold_q == HoldLast) begin
                    if (En && win_x[IDX_W]) begin
                        idx_d  = win_x[IDX_W-1:0];
                        ptr_d  = win_x[IDX_W-1:0] + IDX_W'(1);
                        pre_d  = 1'b1;
                    end
                    hold_d = '0;
                end else if (hold_q != HoldLast) begin
                    hold_d = hold_q + HoldW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        gnt_d = '0;
        if (valid_d) gnt_d[idx_d] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            valid_q <= 1'b0;
            pre_q   <= 1'b0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
            pre_q   <= pre_d;
            gnt_q   <= gnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;
    assign preempt   = pre_q;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Directed and table-driven bench for rr_decode_arbiter with MAX_HOLD=8.
module tb_rr_decode_arbiter;

    logic        clk;
    logic        rst_n;
    logic        En;
    logic [15:0] req;
    logic [15:0] gnt;
    logic [3:0]  gnt_idx;
    logic        gnt_valid;
    logic        preempt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        en;
        logic [15:0] req;
        logic        exp_v;
        logic [3:0]  exp_idx;
        logic        exp_pre;
    } vec_t;

    vec_t tbl[11];

    rr_decode_arbiter #(
        .N_REQ   (16),
        .IDX_W   (4),
        .MAX_HOLD(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .En       (En),
        .req      (req),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .gnt_valid(gnt_valid),
        .preempt  (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, want finish before 100000");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic ev, input logic [3:0] ei,
                         input logic ep);
        logic [15:0] eg;
        eg = '0;
        if (ev) eg[ei] = 1'b1;
        checks++;
        if (gnt_valid !== ev || gnt_idx !== ei || gnt !== eg || preempt !== ep) begin
            errors++;
            $display("FAIL %s: got valid=%b idx=%0d gnt=%h preempt=%b, want valid=%b idx=%0d gnt=%h preempt=%b",
                     name, gnt_valid, gnt_idx, gnt, preempt, ev, ei, eg, ep);
        end
    endtask

    task automatic reset_arb();
        rst_n = 1'b0;
        req   = '0;
        En    = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] dec;
        logic [3:0]  ei;
        logic        ep;

        tbl[0]  = '{1'b1, 16'h8421, 1'b1, 4'd0,  1'b0};
        tbl[1]  = '{1'b1, 16'h8421, 1'b1, 4'd0,  1'b0};
        tbl[2]  = '{1'b1, 16'h8420, 1'b1, 4'd5,  1'b0};
        tbl[3]  = '{1'b1, 16'h8420, 1'b1, 4'd5,  1'b0};
        tbl[4]  = '{1'b1, 16'h8400, 1'b1, 4'd10, 1'b0};
        tbl[5]  = '{1'b1, 16'h8400, 1'b1, 4'd10, 1'b0};
        tbl[6]  = '{1'b1, 16'h8000, 1'b1, 4'd15, 1'b0};
        tbl[7]  = '{1'b1, 16'h8000, 1'b1, 4'd15, 1'b0};
        tbl[8]  = '{1'b1, 16'h0000, 1'b0, 4'd15, 1'b0};
        tbl[9]  = '{1'b1, 16'h8001, 1'b1, 4'd0,  1'b0};
        tbl[10] = '{1'b1, 16'h0000, 1'b0, 4'd0,  1'b0};

        rst_n = 1'b0;
        En    = 1'b0;
        req   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_values", 1'b0, 4'd0, 1'b0);
        rst_n = 1'b1;

        // One-cycle latency, then reset asserted between edges.
        En  = 1'b1;
        req = 16'h0001;
        step();
        check("first_grant", 1'b1, 4'd0, 1'b0);
        #1 rst_n = 1'b0;
        #1 check("async_reset", 1'b0, 4'd0, 1'b0);
        req = '0;
        En  = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            En  = tbl[i].en;
            req = tbl[i].req;
            step();
            check($sformatf("rr_vec%0d", i), tbl[i].exp_v, tbl[i].exp_idx, tbl[i].exp_pre);
        end

        // Two held requesters rotate on timeout every 8 cycles.
        reset_arb();
        En  = 1'b1;
        req = 16'h0003;
        for (int n = 1; n <= 17; n++) begin
            step();
            ei = (n >= 9 && n <= 16) ? 4'd1 : 4'd0;
            ep = (n == 9 || n == 17);
            check($sformatf("hold_rot%0d", n), 1'b1, ei, ep);
        end
        req = 16'h0001;
        for (int n = 0; n < 20; n++) begin
            step();
            check($sformatf("solo_hold%0d", n), 1'b1, 4'd0, 1'b0);
        end
        req = '0;
        step();
        check("solo_release", 1'b0, 4'd0, 1'b0);

        // En=0 blocks new grants and blocks preemption of an existing one.
        En  = 1'b0;
        req = 16'hFFFF;
        for (int n = 0; n < 3; n++) begin
            step();
            check($sformatf("en0_idle%0d", n), 1'b0, 4'd0, 1'b0);
        end
        En = 1'b1;
        step();
        check("en1_grant", 1'b1, 4'd1, 1'b0);
        En = 1'b0;
        for (int n = 0; n < 12; n++) begin
            step();
            check($sformatf("en0_persist%0d", n), 1'b1, 4'd1, 1'b0);
        end
        req = 16'hFFFD;
        step();
        check("en0_release", 1'b0, 4'd1, 1'b0);
        req = '0;

        // Release coinciding with timeout: release wins, no preempt.
        reset_arb();
        En  = 1'b1;
        req = 16'h0011;
        for (int n = 1; n <= 8; n++) begin
            step();
            check($sformatf("coinc_hold%0d", n), 1'b1, 4'd0, 1'b0);
        end
        req = 16'h0010;
        step();
        check("coinc_release", 1'b1, 4'd4, 1'b0);
        step();
        check("coinc_after", 1'b1, 4'd4, 1'b0);

        for (int n = 0; n < 200; n++) begin
            req = 16'($urandom);
            En  = ($urandom_range(0, 3) != 0);
            step();
            dec = '0;
            if (gnt_valid) dec[gnt_idx] = 1'b1;
            checks++;
            if (gnt !== dec || $countones(gnt) > 1) begin
                errors++;
                $display("FAIL rand_onehot%0d: got gnt=%h, want gnt=%h (valid=%b idx=%0d)",
                         n, gnt, dec, gnt_valid, gnt_idx);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
